onehot_pulse_decoder: RTL and testbench
=======================================

// Module: onehot_pulse_decoder
// PURPOSE
//   Binary-to-one-hot pulse decoder; the complement of the 8-to-3 priority encoder.
//   Accepts a binary code through a valid/ready handshake. Drives the matching
//   one-hot output line high for PULSE_LEN cycles, then holds all lines low for
//   GAP_LEN cycles. Re-expands encoded events back onto per-line strobes, for
//   example channel selects or LED/IRQ lines.
// PARAMETERS
//   N_OUT      8                    number of one-hot output lines (2..256)
//   CODE_W     $clog2(N_OUT)        width of the input code (localparam, derived)
//   PULSE_LEN  4                    cycles the selected line stays high (>=1)
//   GAP_LEN    1                    idle cycles, all lines low, after each pulse (>=0)
// PORTS
//   clk       in   1       rising-edge clock
//   rst_n     in   1       synchronous reset, active low
//   in_valid  in   1       a code is offered on in_code
//   in_code   in   CODE_W  binary index of the line to pulse
//   in_ready  out  1       block can accept a code this cycle
//   onehot    out  N_OUT   registered one-hot strobe; all zero when idle
//   busy      out  1       high in PULSE and GAP
//   done      out  1       one-cycle strobe in the last PULSE cycle
//   err       out  1       one-cycle strobe: accepted code >= N_OUT, no pulse made
// BEHAVIOUR
//   Reset:
//     - rst_n low at a rising edge: state=IDLE, onehot=0, busy=0, done=0, err=0,
//       counter=0.
//     - in_ready = (state==IDLE) && rst_n, so it reads 0 while rst_n is low and 1
//       from the first cycle after release.
//   Handshake:
//     - A transfer occurs at an edge where in_valid && in_ready.
//     - in_code is sampled only on a transfer.
//     - in_ready is low in PULSE and GAP. Offers made while busy are not consumed;
//       the source must hold them.
//   States:
//     IDLE  -> PULSE  on transfer with in_code < N_OUT.
//                     onehot <= 1<<in_code, counter <= PULSE_LEN-1.
//     IDLE  -> IDLE   on transfer with in_code >= N_OUT.
//                     err=1 for the next cycle; onehot stays 0.
//     PULSE           onehot held. Counter decrements each cycle.
//                     done=1 in the cycle where counter==0.
//     PULSE -> GAP    at counter==0 when GAP_LEN>0.
//                     onehot <= 0, counter <= GAP_LEN-1.
//     PULSE -> IDLE   at counter==0 when GAP_LEN==0; onehot <= 0.
//     GAP   -> IDLE   at counter==0; otherwise decrement.
//   Timing:
//     - A transfer at edge k drives onehot high from cycle k+1 through cycle
//       k+PULSE_LEN.
//     - in_ready returns high at cycle k+PULSE_LEN+GAP_LEN+1.
//     - Back-to-back codes with GAP_LEN=0 leave exactly one all-zero cycle between
//       pulses: the IDLE cycle.
//   Invariants:
//     - onehot has at most one bit set (onehot is $onehot0 at all times).
//     - busy == (state!=IDLE).
//     - done and err are never high together.
//   Width rules:
//     - Counter width is $clog2(max(PULSE_LEN,GAP_LEN)+1).
//     - The range check compares in_code against N_OUT at CODE_W+1 bits.
//       When N_OUT is a power of two, err can never fire.
//   Reset mid-operation: any state returns to IDLE on the next edge and onehot
//     clears immediately, with no partial pulse. A pending done is suppressed.
//   rst_n low overrides a simultaneous transfer; the code is dropped.
// TESTING
//   1. Reset with in_valid=1, in_code=5 -> onehot=0, in_ready=0; after release,
//      in_ready=1.
//   2. in_code=3, one-cycle valid (defaults) -> onehot=8'h08 for cycles k+1..k+4;
//      done in cycle k+4; 0 in cycle k+5; in_ready=1 at k+6.
//   3. Codes 0..7 held valid back-to-back -> pulses 01,02,..,80, each 4 cycles wide
//      and 2 zero cycles apart; exactly 8 done strobes.
//   4. N_OUT=6, in_code=6 -> err=1 for one cycle, onehot stays 0, in_ready stays 1;
//      then in_code=5 -> onehot=6'h20.
//   5. rst_n low during the 2nd PULSE cycle -> onehot=0 and busy=0 at the next
//      edge, no done; a new code is accepted right after release.
//   6. PULSE_LEN=1, GAP_LEN=0, in_valid stuck at 1, code=2 -> onehot toggles
//      04,00,04,00...; done high on every 04 cycle.

Source files
------------

// File: rtl/onehot_pulse_decoder_if.sv
// rtl/onehot_pulse_decoder_if.sv - code handshake and one-hot strobe bundle
// master offers codes, slave is the decoder producing the strobes.
interface onehot_pulse_decoder_if #(
   parameter int N_OUT = 8
);
   localparam int CODE_W = $clog2(N_OUT);

   logic              in_valid;
   logic [CODE_W-1:0] in_code;
   logic              in_ready;
   logic [N_OUT-1:0]  onehot;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output in_valid, in_code,
      input  in_ready, onehot, busy, done, err
   );

   modport slave (
      input  in_valid, in_code,
      output in_ready, onehot, busy, done, err
   );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - binary code to timed one-hot pulse decoder
// One accepted code lights its line for PULSE_LEN cycles, then GAP_LEN dark cycles.
module onehot_pulse_decoder #(
   parameter int N_OUT     = 8,
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   onehot_pulse_decoder_if.slave  bus
);
   localparam int CODE_W  = $clog2(N_OUT);
   localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int CNT_W   = $clog2(MAX_LEN + 1);
   localparam logic [CODE_W:0]  N_LIM     = N_OUT[CODE_W:0];
   localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_CNT   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             xfer;
   logic             code_ok;

   assign bus.in_ready = (state == IDLE) && rst_n;
   assign bus.busy     = (state != IDLE);
   assign xfer         = bus.in_valid && bus.in_ready;
   // One extra bit so N_OUT itself is representable in the range check.
   assign code_ok      = {1'b0, bus.in_code} < N_LIM;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= '0;
         bus.onehot <= '0;
         bus.done   <= 1'b0;
         bus.err    <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         case (state)
            IDLE: begin
               if (xfer) begin
                  if (code_ok) begin
                     state      <= PULSE;
                     bus.onehot <= N_OUT'(1) << bus.in_code;
                     count      <= PULSE_CNT;
                     bus.done   <= (PULSE_LEN == 1);
                  end else begin
                     bus.err <= 1'b1;
                  end
               end
            end
            PULSE: begin
               if (count == '0) begin
                  bus.onehot <= '0;
                  if (GAP_LEN > 0) begin
                     state <= GAP;
                     count <= GAP_CNT;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  count    <= count - 1'b1;
                  // done is registered, so raise it one edge ahead of count==0.
                  bus.done <= (count == CNT_W'(1));
               end
            end
            GAP: begin
               if (count == '0) state <= IDLE;
               else             count <= count - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb/tb_onehot_pulse_decoder.sv - self-checking bench for onehot_pulse_decoder
// Three configurations run in lockstep against a scripted-waveform reference model.
module tb_onehot_pulse_decoder;
   typedef struct packed {
      logic [7:0] onehot;
      logic       busy;
      logic       done;
      logic       err;
      logic       ready;
   } rec_t;

   typedef struct {
      logic       rst_n;
      logic       valid;
      logic [7:0] code;
      rec_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       v [3];
   logic [7:0] c [3];
   logic       xf [3];
   rec_t       obs [3];
   rec_t       mq [3][$];
   int         nn [3];
   int         pl [3];
   int         gl [3];
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   onehot_pulse_decoder_if #(.N_OUT(8)) if0 ();
   onehot_pulse_decoder_if #(.N_OUT(6)) if1 ();
   onehot_pulse_decoder_if #(.N_OUT(8)) if2 ();

   onehot_pulse_decoder #(.N_OUT(8), .PULSE_LEN(4), .GAP_LEN(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   onehot_pulse_decoder #(.N_OUT(6), .PULSE_LEN(3), .GAP_LEN(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   onehot_pulse_decoder #(.N_OUT(8), .PULSE_LEN(1), .GAP_LEN(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   assign if0.in_valid = v[0];
   assign if1.in_valid = v[1];
   assign if2.in_valid = v[2];
   assign if0.in_code  = c[0][2:0];
   assign if1.in_code  = c[1][2:0];
   assign if2.in_code  = c[2][2:0];
   assign obs[0] = {if0.onehot, if0.busy, if0.done, if0.err, if0.in_ready};
   assign obs[1] = {2'b00, if1.onehot, if1.busy, if1.done, if1.err, if1.in_ready};
   assign obs[2] = {if2.onehot, if2.busy, if2.done, if2.err, if2.in_ready};

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   // Each accepted code schedules the exact future output waveform it implies.
   task automatic step();
      rec_t e;
      rec_t r;
      #1;
      for (int i = 0; i < 3; i++) begin
         e = (mq[i].size() != 0) ? mq[i][0] : rec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
         e.ready = e.ready & rst_n;
         chk($sformatf("model_dut%0d", i), 32'(obs[i]), 32'(e));
         xf[i] = rst_n && v[i] && e.ready;
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (mq[i].size() != 0) void'(mq[i].pop_front());
         if (!rst_n) begin
            mq[i].delete();
         end else if (xf[i]) begin
            if (int'(c[i]) >= nn[i]) begin
               mq[i].push_back(rec_t'{8'h00, 1'b0, 1'b0, 1'b1, 1'b1});
            end else begin
               for (int p = 0; p < pl[i]; p++) begin
                  r = rec_t'{8'd1 << c[i], 1'b1, (p == pl[i] - 1), 1'b0, 1'b0};
                  mq[i].push_back(r);
               end
               for (int g = 0; g < gl[i]; g++)
                  mq[i].push_back(rec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
            end
         end
      end
      @(negedge clk);
   endtask

   vec_t tbl [18];
   int   idx, ndone, npulse, zrun;
   logic [7:0] prev;

   initial begin
      nn = '{8, 6, 8};
      pl = '{4, 3, 1};
      gl = '{1, 2, 0};
      tbl[0]  = '{1'b0, 1'b1, 8'd5, rec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b0}};
      tbl[1]  = '{1'b1, 1'b0, 8'd0, rec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b1}};
      tbl[2]  = '{1'b1, 1'b1, 8'd3, rec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b1}};
      tbl[3]  = '{1'b1, 1'b0, 8'd0, rec_t'{8'h08, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[4]  = '{1'b1, 1'b0, 8'd0, rec_t'{8'h08, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[5]  = '{1'b1, 1'b0, 8'd0, rec_t'{8'h08, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[6]  = '{1'b1, 1'b0, 8'd0, rec_t'{8'h08, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[7]  = '{1'b1, 1'b0, 8'd0, rec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[8]  = '{1'b1, 1'b1, 8'd1, rec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b1}};
      tbl[9]  = '{1'b1, 1'b0, 8'd0, rec_t'{8'h02, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[10] = '{1'b0, 1'b0, 8'd0, rec_t'{8'h02, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[11] = '{1'b1, 1'b1, 8'd6, rec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b1}};
      tbl[12] = '{1'b1, 1'b0, 8'd0, rec_t'{8'h40, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[13] = '{1'b1, 1'b0, 8'd0, rec_t'{8'h40, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[14] = '{1'b1, 1'b0, 8'd0, rec_t'{8'h40, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[15] = '{1'b1, 1'b0, 8'd0, rec_t'{8'h40, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[16] = '{1'b1, 1'b0, 8'd0, rec_t'{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[17] = '{1'b1, 1'b0, 8'd0, rec_t'{8'h00, 1'b0, 1'b0, 1'b0, 1'b1}};

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v[i] = 1'b0;
         c[i] = 8'd0;
         xf[i] = 1'b0;
      end
      v[0] = 1'b1;
      c[0] = 8'd5;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);

      // Reset with a pending offer, single pulse, then reset in the 2nd pulse cycle.
      for (int r = 0; r < 18; r++) begin
         rst_n = tbl[r].rst_n;
         v[0]  = tbl[r].valid;
         c[0]  = tbl[r].code;
         #1;
         chk($sformatf("table_row%0d", r), 32'(obs[0]), 32'(tbl[r].exp));
         step();
      end

      // Codes 0..7 back-to-back on the default configuration.
      idx = 0; ndone = 0; npulse = 0; zrun = 0; prev = 8'h00;
      for (int cy = 0; cy < 56; cy++) begin
         v[0] = (idx < 8);
         c[0] = 8'(idx % 8);
         #1;
         if (obs[0].done) ndone++;
         if (obs[0].onehot != 8'h00 && prev == 8'h00) begin
            chk($sformatf("b2b_pulse%0d", npulse), 32'(obs[0].onehot), 32'(8'd1 << npulse));
            if (npulse > 0) chk($sformatf("b2b_gap%0d", npulse), 32'(zrun), 32'd2);
            npulse++;
            zrun = 0;
         end else if (obs[0].onehot == 8'h00) begin
            zrun++;
         end
         prev = obs[0].onehot;
         step();
         if (xf[0]) idx++;
      end
      v[0] = 1'b0;
      chk("b2b_done_count", 32'(ndone), 32'd8);
      chk("b2b_pulse_count", 32'(npulse), 32'd8);

      // Out-of-range code on N_OUT=6, then a valid one.
      v[1] = 1'b1; c[1] = 8'd6;
      #1;
      chk("err_ready_before", 32'(obs[1].ready), 32'd1);
      step();
      c[1] = 8'd5;
      #1;
      chk("err_strobe", 32'(obs[1].err), 32'd1);
      chk("err_onehot", 32'(obs[1].onehot), 32'd0);
      chk("err_ready", 32'(obs[1].ready), 32'd1);
      step();
      v[1] = 1'b0;
      #1;
      chk("after_err_onehot", 32'(obs[1].onehot), 32'h20);
      chk("after_err_clear", 32'(obs[1].err), 32'd0);
      step();

      // PULSE_LEN=1, GAP_LEN=0 with valid stuck high.
      v[2] = 1'b1; c[2] = 8'd2;
      for (int j = 0; j < 12; j++) begin
         #1;
         chk($sformatf("toggle_onehot%0d", j), 32'(obs[2].onehot), (j % 2 == 1) ? 32'h04 : 32'h00);
         chk($sformatf("toggle_done%0d", j), 32'(obs[2].done), (j % 2 == 1) ? 32'd1 : 32'd0);
         step();
      end
      v[2] = 1'b0;

      for (int cy = 0; cy < 1500; cy++) begin
         rst_n = ($urandom_range(0, 39) != 0);
         for (int i = 0; i < 3; i++) begin
            v[i] = $urandom_range(0, 1) == 1;
            c[i] = 8'($urandom_range(0, 7));
         end
         step();
      end

      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) v[i] = 1'b0;
      for (int cy = 0; cy < 8; cy++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
